fetch_unit: RTL and testbench

//   Instruction fetch stage directly upstream of the control unit / decode stage.

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single outstanding imem read,
// a valid/ready hand-off to decode, PC redirects and misaligned-target halting.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [6:0]  if_opcode,
    output logic        fetch_misaligned
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        mis_q, mis_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= 32'h0000_0013;
            ipc_q   <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        mis_d   = mis_q;
        if (state_q != HALT && redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) begin
                mis_d   = 1'b1;
                valid_d = 1'b0;
                kill_d  = 1'b0;
                state_d = HALT;
            end else begin
                // A redirect during WAIT must still swallow the stale response.
                pc_d    = redirect_pc;
                valid_d = 1'b0;
                kill_d  = (state_q == WAIT) && !imem_rvalid;
                state_d = (state_q == WAIT && !imem_rvalid) ? WAIT : FETCH;
            end
        end else begin
            case (state_q)
                FETCH: state_d = WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = kill_q ? FETCH : HOLD;
                        if (!kill_q) begin
                            instr_d = imem_rdata;
                            ipc_d   = pc_q;
                            pc_d    = pc_q + 32'd4;
                            valid_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        valid_d = 1'b0;
                        state_d = FETCH;
                    end
                end
                default: state_d = HALT;
            endcase
        end
    end

    assign imem_req         = (state_q == FETCH) && !redirect_valid && !reset;
    assign imem_addr        = pc_q;
    assign if_valid         = valid_q;
    assign if_instr         = instr_q;
    assign if_pc            = ipc_q;
    assign if_opcode        = instr_q[6:0];
    assign fetch_misaligned = mis_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; the memory model queues each fetched word,
// redirects retract killed entries, and decode hand-offs are compared in order.
module tb_fetch_unit;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;
    logic        fetch_misaligned;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic        w_pend = 1'b0;
    logic [31:0] w_rdata = 32'h0000_0013;
    logic        w_redir = 1'b0;
    logic [31:0] w_rpc = 32'h0;
    logic        w_ifv;
    logic        w_ifr = 1'b1;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [6:0]  w_op;
    logic        w_mis;

    ent_t        exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] w_log[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          hs_cnt = 0;
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] maddr = 32'h0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_opcode(if_opcode), .fetch_misaligned(fetch_misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect_valid(w_redir), .redirect_pc(w_rpc),
        .if_valid(w_ifv), .if_ready(w_ifr), .if_instr(w_instr),
        .if_pc(w_pc), .if_opcode(w_op), .fetch_misaligned(w_mis)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0019_660D) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Memory model: answers each request lat cycles later and queues the expected hand-off.
    initial forever begin
        logic rv;
        @(negedge clk);
        #1;
        rv = 1'b0;
        if (reset) cnt = 0;
        else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    rv = 1'b1;
                    imem_rdata = mem_word(maddr);
                end
            end
            if (imem_req) begin
                maddr = imem_addr;
                cnt = lat;
                exp_q.push_back('{imem_addr, mem_word(imem_addr)});
                req_log.push_back(imem_addr);
            end
        end
        imem_rvalid = rv;
    end

    initial forever begin
        @(negedge clk);
        #1;
        w_rvalid = w_pend;
        w_pend = w_req && !reset;
        if (w_req) w_log.push_back(w_addr);
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (!reset && if_valid && if_ready) begin
            hs_cnt++;
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                ent_t e;
                e = exp_q.pop_front();
                check("if_pc", if_pc, e.pc);
                check("if_instr", if_instr, e.instr);
                check("if_opcode", if_opcode, e.instr[6:0]);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        req_log.delete();
        w_log.delete();
        #2;
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_instr", if_instr, 32'h13);
        check("rst_pc", if_pc, 0);
        check("rst_mis", fetch_misaligned, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int tgt = hs_cnt + n;
        int k = 0;
        while (hs_cnt < tgt && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("tmo_hs", hs_cnt >= tgt, 1);
    endtask

    task automatic wait_req(output logic [31:0] a);
        int k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while (!imem_req && k < 100);
        check("tmo_req", imem_req, 1);
        a = imem_addr;
    endtask

    task automatic wait_valid();
        int k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while (!if_valid && k < 100);
        check("tmo_valid", if_valid, 1);
    endtask

    task automatic redirect(input logic [31:0] a, input bit drop);
        @(negedge clk);
        redirect_pc = a;
        redirect_valid = 1'b1;
        if (drop && exp_q.size() != 0) void'(exp_q.pop_back());
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
    endtask

    initial begin
        logic [31:0] a, held;
        int reqs;
        do_reset();
        wait_hs(3);
        check("req_cnt", req_log.size() >= 3, 1);
        if (req_log.size() >= 3) begin
            check("addr0", req_log[0], 32'h0);
            check("addr1", req_log[1], 32'h4);
            check("addr2", req_log[2], 32'h8);
        end
        check("w_cnt", w_log.size() >= 2, 1);
        if (w_log.size() >= 2) begin
            check("w_addr0", w_log[0], 32'hFFFF_FFFC);
            check("w_addr1", w_log[1], 32'h0);
        end
        @(negedge clk);
        if_ready = 1'b0;
        wait_valid();
        held = if_instr;
        check("hold_pc", if_pc, 32'hC);
        check("hold_instr", held, mem_word(32'hC));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            check("hold_valid", if_valid, 1);
            check("hold_stable", if_instr, held);
            check("hold_noreq", imem_req, 0);
        end
        @(negedge clk);
        if_ready = 1'b1;
        lat = 3;
        wait_hs(1);
        wait_req(a);
        redirect(32'h100, 1);
        wait_req(a);
        check("redir_wait_addr", a, 32'h100);
        check("redir_wait_novalid", if_valid, 0);
        lat = 1;
        wait_hs(1);
        @(negedge clk);
        if_ready = 1'b0;
        wait_valid();
        check("hold2_pc", if_pc, 32'h104);
        redirect(32'h200, 1);
        check("redir_hold_valid", if_valid, 0);
        check("redir_hold_req", imem_req, 1);
        check("redir_hold_addr", imem_addr, 32'h200);
        @(negedge clk);
        if_ready = 1'b1;
        wait_hs(1);
        wait_req(a);
        redirect(32'h102, 1);
        check("mis_flag", fetch_misaligned, 1);
        check("mis_valid", if_valid, 0);
        reqs = 0;
        redirect(32'h300, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            reqs += int'(imem_req);
        end
        check("halt_noreq", reqs, 0);
        check("halt_flag", fetch_misaligned, 1);
        do_reset();
        wait_hs(1);
        check("restart_cnt", req_log.size() >= 1, 1);
        if (req_log.size() >= 1) check("restart_addr", req_log[0], 32'h0);
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
